// File: rtl/fifo_pkg.sv
// Shared constants and sizing helpers for the button-driven FIFO family.
package fifo_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 8;

  // Request strobe encodings for the EDGE_MODE parameter.
  localparam int EDGE_LEVEL = 0;
  localparam int EDGE_RISE  = 1;

  function automatic int ptr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/btn_strobe.sv
// Turns a debounced button into a one-cycle request (rising edge) or a
// per-cycle request (level), depending on EDGE_MODE.
module btn_strobe
  import fifo_pkg::*;
#(
  parameter int EDGE_MODE = EDGE_RISE
) (
  input  logic CLK,
  input  logic RST,
  input  logic i_btn,
  output logic o_req
);

  logic r_btn_q;

  // Cleared on reset so a button held through reset release reads as a new press.
  always_ff @(posedge CLK) begin
    if (RST) r_btn_q <= 1'b0;
    else     r_btn_q <= i_btn;
  end

  assign o_req = (EDGE_MODE == EDGE_RISE) ? (i_btn & ~r_btn_q) : i_btn;

endmodule

// File: rtl/btn_fifo.sv
// Button-driven circular FIFO with occupancy count, almost-full/empty
// thresholds and sticky overflow/underflow flags.
module btn_fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter int AF_LEVEL  = DEPTH - 1,
  parameter int AE_LEVEL  = 1,
  parameter int EDGE_MODE = EDGE_RISE,
  localparam int PW = ptr_width(DEPTH),
  localparam int CW = cnt_width(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] DATA_INPUT,
  input  logic             BTN_WRITE,
  input  logic             BTN_READ,
  output logic [WIDTH-1:0] DATA_OUT,
  output logic             EMPTY,
  output logic             FULL,
  output logic             ALMOST_FULL,
  output logic             ALMOST_EMPTY,
  output logic [CW-1:0]    COUNT,
  output logic             OVERFLOW,
  output logic             UNDERFLOW
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_dout;
  logic             r_ovf;
  logic             r_unf;

  logic w_wr_req;
  logic w_rd_req;
  logic w_wr_acc;
  logic w_rd_acc;

  btn_strobe #(.EDGE_MODE(EDGE_MODE)) u_wr_strobe (
    .CLK   (CLK),
    .RST   (RST),
    .i_btn (BTN_WRITE),
    .o_req (w_wr_req)
  );

  btn_strobe #(.EDGE_MODE(EDGE_MODE)) u_rd_strobe (
    .CLK   (CLK),
    .RST   (RST),
    .i_btn (BTN_READ),
    .o_req (w_rd_req)
  );

  // A request is offered for one cycle and either accepted or dropped; there is
  // no back-pressure. A write into a full store is accepted only when a read
  // frees a slot on the same edge; a read of an empty store never falls through.
  assign w_wr_acc = w_wr_req & (~FULL | w_rd_req);
  assign w_rd_acc = w_rd_req & ~EMPTY;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    else                     return p + PW'(1);
  endfunction

  always_ff @(posedge CLK) begin
    if (!RST && w_wr_acc) r_mem[r_wr_ptr] <= DATA_INPUT;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_dout   <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_rd_acc) begin
        r_rd_ptr <= next_ptr(r_rd_ptr);
        r_dout   <= r_mem[r_rd_ptr];
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_wr_req && !w_wr_acc) r_ovf <= 1'b1;
      if (w_rd_req && !w_rd_acc) r_unf <= 1'b1;
    end
  end

  assign DATA_OUT     = r_dout;
  assign COUNT        = r_count;
  assign EMPTY        = (r_count == '0);
  assign FULL         = (r_count == CW'(DEPTH));
  assign ALMOST_FULL  = (r_count >= CW'(AF_LEVEL));
  assign ALMOST_EMPTY = (r_count <= CW'(AE_LEVEL));
  assign OVERFLOW     = r_ovf;
  assign UNDERFLOW    = r_unf;

endmodule

// File: doc/btn_fifo.md
# btn_fifo

Parametrised successor to the team's 8-bit button-driven FIFO. It buffers WIDTH-bit words in a DEPTH-entry circular store. Each write and read is triggered by a button level or a button rising edge, selected by the EDGE_MODE parameter. It adds occupancy count, almost-full/almost-empty thresholds and sticky overflow/underflow flags, and sits between a switch/button input stage and a display or downstream consumer.

## Interface
- WIDTH, 8: data word width in bits, ≥1
- DEPTH, 8: number of entries, ≥2, any integer (not restricted to powers of two)
- AF_LEVEL, DEPTH-1: ALMOST_FULL asserts when COUNT ≥ AF_LEVEL
- AE_LEVEL, 1: ALMOST_EMPTY asserts when COUNT ≤ AE_LEVEL
- EDGE_MODE, 1: 1 = one operation per rising edge of the button; 0 = one operation per cycle while the button is high
- CLK  in  1  single clock, all logic on rising edge
- RST  in  1  synchronous, active-high reset
- DATA_INPUT  in  WIDTH  word to write
- BTN_WRITE  in  1  write request
- BTN_READ  in  1  read request
- DATA_OUT  out  WIDTH  registered last-read word
- EMPTY  out  1  COUNT == 0
- FULL  out  1  COUNT == DEPTH
- ALMOST_FULL  out  1  COUNT ≥ AF_LEVEL
- ALMOST_EMPTY  out  1  COUNT ≤ AE_LEVEL
- COUNT  out  $clog2(DEPTH+1)  current occupancy
- OVERFLOW  out  1  sticky: a write was dropped
- UNDERFLOW  out  1  sticky: a read was dropped

## Operation
- Request strobes:
  - EDGE_MODE=1: wr_req = BTN_WRITE & ~btn_write_q, with btn_write_q the button registered one cycle earlier. rd_req is formed the same way from BTN_READ.
  - EDGE_MODE=0: wr_req = BTN_WRITE, rd_req = BTN_READ.
- Accepted write: wr_req & (~FULL | rd_req). Stores DATA_INPUT at wr_ptr and advances wr_ptr.
- Accepted read: rd_req & ~EMPTY. Loads mem[rd_ptr] into DATA_OUT and advances rd_ptr.
- Pointers, width $clog2(DEPTH): wrap from DEPTH-1 to 0 by explicit compare. Power-of-two overflow is not relied on.
- COUNT: +1 on write only, −1 on read only, unchanged when both are accepted or neither is.
- Boundary cases:
  - Full, read and write together: both accepted. COUNT stays DEPTH and FULL stays high.
  - Empty, read and write together: write accepted, read rejected. UNDERFLOW sets, DATA_OUT is held and COUNT becomes 1. There is no fall-through.
  - Write while full with no read: word dropped, OVERFLOW sets, state unchanged.
  - Read while empty: UNDERFLOW sets, DATA_OUT is held.
- OVERFLOW and UNDERFLOW clear only on RST.
- Flags are derived combinationally from registered COUNT, so they are glitch-free with respect to CLK.

## Timing
- Reset values: DATA_OUT=0, COUNT=0, EMPTY=1, FULL=0, ALMOST_EMPTY=1 (AE_LEVEL≥0), ALMOST_FULL=0 (AF_LEVEL≥1), OVERFLOW=0, UNDERFLOW=0.
- Also cleared on reset: wr_ptr, rd_ptr, btn_write_q, btn_read_q.
- Memory contents are not reset.
- RST wins over any simultaneous request.
- Reset mid-operation discards all stored words on that edge.
- A button held high at reset release counts as a rising edge on the first cycle after release.
- Write: takes effect on the first CLK edge where BTN_WRITE is sampled high. COUNT, EMPTY and FULL reflect it immediately after that edge.
- Read latency is 1: DATA_OUT shows the popped word right after the edge that accepts the read.
- EDGE_MODE=1: a held button yields exactly one operation. The button must be low for at least one sampled cycle before it re-arms.
- No debouncing is done inside the block. Debounced button inputs are provided upstream.

## Structure
- Shared package `fifo_pkg`: the pointer-width and count-width functions (wrappers around $clog2), default WIDTH/DEPTH constants, and the EDGE_MODE encodings EDGE_LEVEL=0 and EDGE_RISE=1.
- One sub-module, `btn_strobe`: a parametrised edge/level strobe generator with a synchronous reset. It is instantiated twice, once for write and once for read.
- Storage is a plain register array inferred inside btn_fifo. There is no separate RAM module.

## Test plan
- Reset, then EDGE_MODE=1: write 0x01, 0x02, 0x04, 0x08 with 20 ns pulses, then two reads.
  - After the writes: COUNT=4.
  - After the reads: DATA_OUT=0x01, then 0x02; COUNT=2.
  - Then write 0x10 and 0x20: COUNT=4, EMPTY=0, FULL=0.
- Fill DEPTH=8 with 0x00..0x07, then a 9th write of 0xAA.
  - FULL=1, OVERFLOW=1, COUNT=8.
  - Reading all 8 returns 0x00..0x07 in order.
  - EMPTY=1 and ALMOST_EMPTY=1 at the end.
- Wrap-around at DEPTH=5: 12 interleaved write/read pairs (write, then read of the same word).
  - Data is returned in order with no loss.
  - COUNT never exceeds 1.
  - Pointers pass index 4→0 at least twice.
- Simultaneous edges:
  - When full: both accepted, COUNT stays 8, and the oldest word appears on DATA_OUT.
  - When empty: COUNT becomes 1, UNDERFLOW=1, DATA_OUT unchanged.
- BTN_WRITE held high for 5 cycles:
  - EDGE_MODE=1: exactly 1 write.
  - EDGE_MODE=0: 5 writes.
- RST asserted with 3 words stored: next cycle COUNT=0, EMPTY=1, DATA_OUT=0 and sticky flags cleared.
